// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong per-frame game controller.
package pong_pkg;

    // Default screen and game geometry, in pixels / frames / points
    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_X_E   = 16;
    localparam int DEF_PADDLE_X_D   = 616;
    localparam int DEF_PADDLE_STEP  = 4;
    localparam int DEF_BALL_STEP    = 2;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_POINT_FRAMES = 60;

    // Match state, encoded exactly as presented on game_state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    // Per-frame update sequence started by frame_tick
    typedef enum logic [1:0] {
        SEQ_WAIT,
        SEQ_UPD_PAD,
        SEQ_UPD_BALL,
        SEQ_COMMIT
    } seq_state_t;

    // Signed coordinate with one spare bit so steps past the edges never wrap
    typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Frame tick, buttons and game outputs exchanged between the controller and its surroundings.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic [3:0] buttons_export;
    logic [9:0] bola_x;
    logic [9:0] bola_y;
    logic [9:0] barra_e_y;
    logic [9:0] barra_d_y;
    logic [3:0] score_e;
    logic [3:0] score_d;
    logic       score_upd;
    logic [1:0] game_state;

    modport master (
        output frame_tick, buttons_export,
        input  bola_x, bola_y, barra_e_y, barra_d_y,
        input  score_e, score_d, score_upd, game_state
    );

    modport slave (
        input  frame_tick, buttons_export,
        output bola_x, bola_y, barra_e_y, barra_d_y,
        output score_e, score_d, score_upd, game_state
    );
endinterface

// File: rtl/pong_btn_sync.sv
// Two-flop synchronizer for the active-low keys plus an "any key newly pressed" detector.
module pong_btn_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys_raw,
    output logic [3:0] pressed,
    output logic       any_rise
);
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;

    // Synchronize the raw keys (idle high) and remember last cycle's pressed set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
            prev  <= pressed;
        end
    end

    assign pressed  = ~sync2;
    assign any_rise = |(pressed & ~prev);
endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame Pong controller: paddles, ball, wall/paddle/goal events and score.
// All work is done in shadow registers and published together on the COMMIT edge.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_X_E   = DEF_PADDLE_X_E,
    parameter int PADDLE_X_D   = DEF_PADDLE_X_D,
    parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
    parameter int BALL_STEP    = DEF_BALL_STEP,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
    input logic              clk_clk,
    input logic              reset_reset,
    pong_game_ctrl_if.slave  bus
);
    localparam coord_t ZERO     = '0;
    localparam coord_t PAD_MAX  = coord_t'(V_RES - PADDLE_H);
    localparam coord_t PAD_INIT = coord_t'((V_RES - PADDLE_H) / 2);
    localparam coord_t Y_MAX    = coord_t'(V_RES - BALL_SIZE);
    localparam coord_t X_HIT_E  = coord_t'(PADDLE_X_E + PADDLE_W);
    localparam coord_t X_HIT_D  = coord_t'(PADDLE_X_D - BALL_SIZE);
    localparam coord_t X_GOAL_D = coord_t'(H_RES - BALL_SIZE);
    localparam coord_t CX       = coord_t'((H_RES - BALL_SIZE) / 2);
    localparam coord_t CY       = coord_t'((V_RES - BALL_SIZE) / 2);

    logic [3:0]  pressed;
    logic        any_rise;
    logic        press_pend;
    seq_state_t  seq, seq_next;

    coord_t      pad_e, pad_d, ball_x, ball_y;
    logic        dir_x, dir_y;          // 1 = right / down
    logic [3:0]  score_e, score_d;
    game_state_t state;
    logic [7:0]  point_cnt;
    logic        score_chg;

    coord_t      next_x, next_y;
    logic        next_dx, next_dy;
    logic [3:0]  next_se, next_sd;
    game_state_t next_st;
    logic [7:0]  next_cnt;
    logic        next_chg;

    // Paddle step with clamping to the visible range; opposing keys cancel
    function automatic coord_t move_pad(coord_t y, logic up, logic dn);
        coord_t n;
        n = y;
        if (up && !dn)
            n = y - coord_t'(PADDLE_STEP);
        else if (dn && !up)
            n = y + coord_t'(PADDLE_STEP);
        if (n < ZERO)
            n = ZERO;
        else if (n > PAD_MAX)
            n = PAD_MAX;
        return n;
    endfunction

    // Ball rows intersect paddle rows
    function automatic logic overlap(coord_t by, coord_t py);
        return ((by + coord_t'(BALL_SIZE)) > py) && (by < (py + coord_t'(PADDLE_H)));
    endfunction

    pong_btn_sync u_btn_sync (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .keys_raw (bus.buttons_export),
        .pressed  (pressed),
        .any_rise (any_rise)
    );

    // Hold a new press until the next commit so presses between frames are not lost
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            press_pend <= 1'b0;
        else
            press_pend <= any_rise | (press_pend & (seq != SEQ_COMMIT));
    end

    // Frame sequencer state register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            seq <= SEQ_WAIT;
        else
            seq <= seq_next;
    end

    // Frame sequencer next state; ticks outside SEQ_WAIT are ignored
    always_comb begin
        seq_next = seq;
        case (seq)
            SEQ_WAIT:     if (bus.frame_tick) seq_next = SEQ_UPD_PAD;
            SEQ_UPD_PAD:  seq_next = SEQ_UPD_BALL;
            SEQ_UPD_BALL: seq_next = SEQ_COMMIT;
            SEQ_COMMIT:   seq_next = SEQ_WAIT;
        endcase
    end

    // Ball, score and match-state update evaluated against the freshly moved paddles
    always_comb begin
        next_x   = ball_x;
        next_y   = ball_y;
        next_dx  = dir_x;
        next_dy  = dir_y;
        next_se  = score_e;
        next_sd  = score_d;
        next_st  = state;
        next_cnt = point_cnt;
        next_chg = 1'b0;
        case (state)
            ST_IDLE: if (press_pend) next_st = ST_PLAY;
            ST_PLAY: begin
                next_x = dir_x ? ball_x + coord_t'(BALL_STEP) : ball_x - coord_t'(BALL_STEP);
                next_y = dir_y ? ball_y + coord_t'(BALL_STEP) : ball_y - coord_t'(BALL_STEP);
                if (next_y <= ZERO) begin
                    next_y  = ZERO;
                    next_dy = ~dir_y;
                end else if (next_y >= Y_MAX) begin
                    next_y  = Y_MAX;
                    next_dy = ~dir_y;
                end
                // Paddle hits use the wall-corrected row of this frame
                if (!dir_x && next_x <= X_HIT_E && overlap(next_y, pad_e)) begin
                    next_x  = X_HIT_E;
                    next_dx = ~dir_x;
                end else if (dir_x && next_x >= X_HIT_D && overlap(next_y, pad_d)) begin
                    next_x  = X_HIT_D;
                    next_dx = ~dir_x;
                end else if (next_x <= ZERO) begin
                    next_sd  = score_d + 4'd1;
                    next_chg = 1'b1;
                    next_x   = CX;
                    next_y   = CY;
                    next_dx  = 1'b0;
                    next_cnt = '0;
                    next_st  = (next_sd == 4'(WIN_SCORE)) ? ST_OVER : ST_POINT;
                end else if (next_x >= X_GOAL_D) begin
                    next_se  = score_e + 4'd1;
                    next_chg = 1'b1;
                    next_x   = CX;
                    next_y   = CY;
                    next_dx  = 1'b1;
                    next_cnt = '0;
                    next_st  = (next_se == 4'(WIN_SCORE)) ? ST_OVER : ST_POINT;
                end
            end
            ST_POINT: begin
                if (point_cnt == 8'(POINT_FRAMES - 1)) begin
                    next_cnt = '0;
                    next_st  = ST_PLAY;
                end else begin
                    next_cnt = point_cnt + 8'd1;
                end
            end
            ST_OVER: begin
                if (press_pend) begin
                    next_se  = '0;
                    next_sd  = '0;
                    next_chg = 1'b1;
                    next_st  = ST_IDLE;
                end
            end
        endcase
    end

    // Shadow registers: paddles move in UPD_PAD, everything else lands in UPD_BALL
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pad_e     <= PAD_INIT;
            pad_d     <= PAD_INIT;
            ball_x    <= CX;
            ball_y    <= CY;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            score_e   <= '0;
            score_d   <= '0;
            state     <= ST_IDLE;
            point_cnt <= '0;
            score_chg <= 1'b0;
        end else begin
            if (seq == SEQ_UPD_PAD && state != ST_OVER) begin
                pad_e <= move_pad(pad_e, pressed[0], pressed[1]);
                pad_d <= move_pad(pad_d, pressed[2], pressed[3]);
            end
            if (seq == SEQ_UPD_BALL) begin
                ball_x    <= next_x;
                ball_y    <= next_y;
                dir_x     <= next_dx;
                dir_y     <= next_dy;
                score_e   <= next_se;
                score_d   <= next_sd;
                state     <= next_st;
                point_cnt <= next_cnt;
                score_chg <= next_chg;
            end
        end
    end

    // Published outputs change together on the COMMIT edge; score_upd lasts one cycle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bus.bola_x     <= 10'(CX);
            bus.bola_y     <= 10'(CY);
            bus.barra_e_y  <= 10'(PAD_INIT);
            bus.barra_d_y  <= 10'(PAD_INIT);
            bus.score_e    <= '0;
            bus.score_d    <= '0;
            bus.score_upd  <= 1'b0;
            bus.game_state <= ST_IDLE;
        end else begin
            bus.score_upd <= 1'b0;
            if (seq == SEQ_COMMIT) begin
                bus.bola_x     <= ball_x[9:0];
                bus.bola_y     <= ball_y[9:0];
                bus.barra_e_y  <= pad_e[9:0];
                bus.barra_d_y  <= pad_d[9:0];
                bus.score_e    <= score_e;
                bus.score_d    <= score_d;
                bus.score_upd  <= score_chg;
                bus.game_state <= state;
            end
        end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: button/paddle vector table, then one long
// hand-traced rally (walls, both paddles, goals) through to game over and reset.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   upd_cnt = 0;
    int   n = 0;          // number of PLAY frames in which the ball has moved

    always #5 clk = ~clk;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    // Count score_upd cycles
    always @(negedge clk) if (bus.score_upd) upd_cnt++;

    typedef struct {
        logic [3:0] keys;   // pressed = 1: [0] L up, [1] L down, [2] R up, [3] R down
        int st;
        int pe;
        int pd;
        int bx;
        int by;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, ".bola_x"}, int'(bus.bola_x), x);
        check({tag, ".bola_y"}, int'(bus.bola_y), y);
    endtask

    task automatic check_reset(input string tag);
        check_ball(tag, 316, 236);
        check({tag, ".barra_e_y"}, int'(bus.barra_e_y), 208);
        check({tag, ".barra_d_y"}, int'(bus.barra_d_y), 208);
        check({tag, ".score_e"}, int'(bus.score_e), 0);
        check({tag, ".score_d"}, int'(bus.score_d), 0);
        check({tag, ".score_upd"}, int'(bus.score_upd), 0);
        check({tag, ".game_state"}, int'(bus.game_state), 0);
    endtask

    // One frame: apply keys, let them settle, pulse the tick, wait past the commit
    task automatic do_frame(input logic [3:0] keys);
        bus.buttons_export = ~keys;
        repeat (3) @(posedge clk);
        #1 bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, input logic [3:0] keys);
        while (n < target) begin
            do_frame(keys);
            n++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int m;
        tbl[0] = '{4'b0001, 1, 204, 208, 316, 236};
        tbl[1] = '{4'b0011, 1, 204, 208, 318, 238};
        tbl[2] = '{4'b0010, 1, 208, 208, 320, 240};
        tbl[3] = '{4'b0100, 1, 208, 204, 322, 242};
        tbl[4] = '{4'b1000, 1, 208, 208, 324, 244};
        tbl[5] = '{4'b0001, 1, 204, 208, 326, 246};

        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.buttons_export = 4'hF;
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1 check_reset("after_reset");

        // Key table: first press leaves IDLE, then single/double keys on both paddles
        for (int i = 0; i < 6; i++) begin
            do_frame(tbl[i].keys);
            check($sformatf("vec%0d.state", i), int'(bus.game_state), tbl[i].st);
            check($sformatf("vec%0d.pad_e", i), int'(bus.barra_e_y), tbl[i].pe);
            check($sformatf("vec%0d.pad_d", i), int'(bus.barra_d_y), tbl[i].pd);
            check_ball($sformatf("vec%0d", i), tbl[i].bx, tbl[i].by);
        end
        n = 5;

        // Left paddle held down reaches the bottom clamp and stays
        run_until(64, 4'b0010);
        check("pad_e_clamp_lo", int'(bus.barra_e_y), 416);
        run_until(65, 4'b0010);
        check("pad_e_clamp_hold", int'(bus.barra_e_y), 416);
        check_ball("n65", 446, 366);

        // Bottom wall, then right paddle (held at 416) bounce
        run_until(118, 4'b1000);
        check_ball("bottom_wall", 552, 472);
        check("pad_d_clamp", int'(bus.barra_d_y), 416);
        run_until(119, 4'b1000);
        check_ball("after_bottom", 554, 470);
        run_until(145, 4'b1000);
        check_ball("before_rpad", 606, 418);
        run_until(146, 4'b1000);
        check_ball("rpad_hit", 608, 416);
        run_until(147, 4'b0001);
        check_ball("after_rpad", 606, 414);
        check("pad_e_up", int'(bus.barra_e_y), 412);

        // Left paddle up to 140, top wall bounce at y=2 -> 0 -> 2
        run_until(215, 4'b0001);
        check("pad_e_140", int'(bus.barra_e_y), 140);
        run_until(353, 4'b0000);
        check_ball("top_y2", 194, 2);
        run_until(354, 4'b0000);
        check_ball("top_y0", 192, 0);
        run_until(355, 4'b0000);
        check_ball("top_back", 190, 2);

        // Left paddle bounce clamps x to 24
        run_until(437, 4'b0000);
        check_ball("before_lpad", 26, 166);
        run_until(438, 4'b0000);
        check_ball("lpad_hit", 24, 168);
        run_until(439, 4'b0100);
        check_ball("after_lpad", 26, 170);

        // Right paddle up to 192, ball returns off the right paddle
        run_until(494, 4'b0100);
        check("pad_d_192", int'(bus.barra_d_y), 192);
        run_until(590, 4'b0000);
        check_ball("bottom2", 328, 472);
        run_until(730, 4'b0000);
        check_ball("rpad_hit2", 608, 192);
        run_until(731, 4'b0000);
        check_ball("after_rpad2", 606, 190);

        // Ball misses the left paddle: right player scores
        run_until(1033, 4'b0000);
        check_ball("before_goal", 2, 414);
        check("before_goal.state", int'(bus.game_state), 1);
        base = upd_cnt;
        run_until(1034, 4'b0000);
        check("goal1.state", int'(bus.game_state), 2);
        check("goal1.score_d", int'(bus.score_d), 1);
        check("goal1.score_e", int'(bus.score_e), 0);
        check("goal1.upd_pulses", upd_cnt - base, 1);
        check_ball("goal1_centre", 316, 236);

        // Freeze for 60 ticks, serve toward the left, repeat until 9 points
        for (int k = 1; k < 9; k++) begin
            for (int p = 1; p <= 60; p++) begin
                do_frame(4'b0000);
                check($sformatf("point%0d.state_t%0d", k, p), int'(bus.game_state), (p < 60) ? 2 : 1);
            end
            check_ball($sformatf("serve%0d", k), 316, 236);
            base = upd_cnt;
            m = 0;
            while (m < 200 && int'(bus.score_d) == k) begin
                do_frame(4'b0000);
                m++;
                if (k == 1 && m == 1) check_ball("serve_first_step", 314, 238);
            end
            check($sformatf("rally%0d.frames", k), m, 158);
            check($sformatf("rally%0d.score_d", k), int'(bus.score_d), k + 1);
            check($sformatf("rally%0d.score_e", k), int'(bus.score_e), 0);
            check($sformatf("rally%0d.upd_pulses", k), upd_cnt - base, 1);
            check($sformatf("rally%0d.state", k), int'(bus.game_state), (k + 1 == 9) ? 3 : 2);
        end

        // Game over: everything frozen until a new press
        do_frame(4'b0000);
        check("over.state", int'(bus.game_state), 3);
        check("over.score_d", int'(bus.score_d), 9);
        check_ball("over", 316, 236);
        check("over.pad_e", int'(bus.barra_e_y), 140);
        check("over.pad_d", int'(bus.barra_d_y), 192);
        base = upd_cnt;
        do_frame(4'b0001);
        check("restart.state", int'(bus.game_state), 0);
        check("restart.score_d", int'(bus.score_d), 0);
        check("restart.score_e", int'(bus.score_e), 0);
        check("restart.upd_pulses", upd_cnt - base, 1);
        check("restart.pad_e_frozen", int'(bus.barra_e_y), 140);

        // Idle with no new press, then a press starts play
        do_frame(4'b0000);
        check("idle_hold.state", int'(bus.game_state), 0);
        do_frame(4'b0001);
        check("replay.state", int'(bus.game_state), 1);
        check("replay.pad_e", int'(bus.barra_e_y), 136);

        // Asynchronous reset in the middle of UPD_BALL
        bus.buttons_export = 4'hF;
        @(posedge clk);
        #1 bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset("async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_frame(4'b0001);
        check("post_reset.state", int'(bus.game_state), 1);
        check("post_reset.pad_e", int'(bus.barra_e_y), 204);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
